vliw_program_loader: RTL and testbench

VLIW_PROGRAM_LOADER -- requirements
Module: vliw_program_loader

---
 rtl/vliw_pkg.sv | 23 ++
 rtl/vliw_program_loader_if.sv | 15 +
 rtl/vliw_word_assembler.sv | 46 ++++
 rtl/vliw_program_loader.sv | 173 +++++++++++++++++
 tb/tb_vliw_program_loader.sv | 374 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vliw_pkg.sv
// Shared constants and FSM state encoding for the VLIW program loader.
// The CHECK state exists only when VLIW_LOADER_CHECKSUM_EN is defined.
package vliw_pkg;

  localparam int VLIW_ADDR_W  = 9;
  localparam int VLIW_DATA_W  = 72;
  localparam int BEAT_W       = 16;
  localparam int BEATS        = 5;
  localparam int BEAT_IDX_W   = 3;

  // Explicit encodings keep RUN/ERROR stable whether or not CHECK is built.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    WRITE   = 3'd2,
`ifdef VLIW_LOADER_CHECKSUM_EN
    CHECK   = 3'd3,
`endif
    RUN     = 3'd4,
    ERROR   = 3'd5
  } state_t;

endpackage

// File: rtl/vliw_program_loader_if.sv
// Host beat bus of the VLIW program loader.
// Handshake: a beat transfers on a rising clock edge where host_valid and
// host_ready are both high; host_data/host_last must be stable while
// host_valid is high, and host_valid may drop at any time (stalls are legal).
interface vliw_program_loader_if;
  logic [15:0] host_data;
  logic        host_valid;
  logic        host_ready;
  logic        host_last;

  modport master (output host_data, output host_valid, output host_last,
                  input  host_ready);
  modport slave  (input  host_data, input  host_valid, input  host_last,
                  output host_ready);
endinterface

// File: rtl/vliw_word_assembler.sv
// Collects five 16-bit beats into one 72-bit VLIW word.
// Beat 0 lands in [15:0] ... beat 3 in [63:48]; beat 4 contributes only its
// low byte to [71:64]. word_ready is high in the cycle beat 4 is accepted.
module vliw_word_assembler
  import vliw_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clear,
  input  logic                  i_beat_valid,
  input  logic [BEAT_W-1:0]     i_beat,
  output logic [VLIW_DATA_W-1:0] o_word,
  output logic [BEAT_IDX_W-1:0] o_beat_idx,
  output logic                  o_word_ready
);

  localparam logic [BEAT_IDX_W-1:0] LAST_IDX = BEAT_IDX_W'(BEATS - 1);

  logic [VLIW_DATA_W-1:0] r_word;
  logic [BEAT_IDX_W-1:0]  r_idx;

  assign o_word_ready = i_beat_valid && (r_idx == LAST_IDX);
  assign o_word       = r_word;
  assign o_beat_idx   = r_idx;

  // Place each accepted beat at its slot; the counter wraps after beat 4.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= '0;
      r_idx  <= '0;
    end else if (i_clear) begin
      r_word <= '0;
      r_idx  <= '0;
    end else if (i_beat_valid) begin
      case (r_idx)
        3'd0:    r_word[15:0]  <= i_beat;
        3'd1:    r_word[31:16] <= i_beat;
        3'd2:    r_word[47:32] <= i_beat;
        3'd3:    r_word[63:48] <= i_beat;
        default: r_word[71:64] <= i_beat[7:0];
      endcase
      r_idx <= o_word_ready ? '0 : r_idx + BEAT_IDX_W'(1);
    end
  end

endmodule

// File: rtl/vliw_program_loader.sv
// VLIW program loader: receives host beats, assembles 72-bit words, writes
// them to program memory and optionally starts the VLIW sequencer.
// Optional feature macro: VLIW_LOADER_CHECKSUM_EN adds a trailing 16-bit
// checksum beat verified in the CHECK state before the load completes.
module vliw_program_loader
  import vliw_pkg::*;
#(
  parameter int ADDR_W = VLIW_ADDR_W,
  parameter int DATA_W = VLIW_DATA_W
) (
  input  logic                 clock_200,
  input  logic                 reset_n,
  input  logic                 load_request,
  input  logic                 auto_start,
  vliw_program_loader_if.slave host,
  output logic                 write_enable,
  output logic [ADDR_W-1:0]    write_address,
  output logic [DATA_W-1:0]    write_data,
  output logic                 vliw_start,
  output logic                 load_done,
  output logic                 load_error,
  output logic [ADDR_W:0]      word_count,
  output state_t               o_dbg_state
);

  localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_W-1:0]     r_addr;
  logic [ADDR_W:0]       r_count;
  logic                  r_done;
  logic                  r_err;
  logic                  r_last;
  logic                  w_host_ready;
  logic                  w_accept;
  logic                  w_asm_valid;
  logic                  w_word_ready;
  logic [BEAT_IDX_W-1:0] w_beat_idx;
  logic [DATA_W-1:0]     w_word;
  logic                  w_set_done;
  logic                  w_set_err;
`ifdef VLIW_LOADER_CHECKSUM_EN
  logic [BEAT_W-1:0]     r_sum;
`endif

`ifdef VLIW_LOADER_CHECKSUM_EN
  assign w_host_ready = (r_state == COLLECT) || (r_state == CHECK);
`else
  assign w_host_ready = (r_state == COLLECT);
`endif
  // A beat coinciding with load_request is dropped together with the old load.
  assign w_accept    = host.host_valid && w_host_ready && !load_request;
  assign w_asm_valid = w_accept && (r_state == COLLECT);

  vliw_word_assembler u_asm (
    .clk          (clock_200),
    .rst_n        (reset_n),
    .i_clear      (load_request),
    .i_beat_valid (w_asm_valid),
    .i_beat       (host.host_data),
    .o_word       (w_word),
    .o_beat_idx   (w_beat_idx),
    .o_word_ready (w_word_ready)
  );

  // State register.
  always_ff @(posedge clock_200 or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic and status set strobes.
  always_comb begin
    w_next     = r_state;
    w_set_done = 1'b0;
    w_set_err  = 1'b0;
    if (load_request) begin
      w_next = COLLECT;
    end else begin
      case (r_state)
        IDLE: ;
        COLLECT: begin
          if (w_accept) begin
            if ((w_beat_idx == '0) && (r_count == CAPACITY)) begin
              w_next    = ERROR;
              w_set_err = 1'b1;
            end else if (host.host_last && !w_word_ready) begin
              w_next    = ERROR;
              w_set_err = 1'b1;
            end else if (w_word_ready) begin
              w_next = WRITE;
            end
          end
        end
        WRITE: begin
          if (r_last) begin
`ifdef VLIW_LOADER_CHECKSUM_EN
            w_next = CHECK;
`else
            w_next     = auto_start ? RUN : IDLE;
            w_set_done = 1'b1;
`endif
          end else begin
            w_next = COLLECT;
          end
        end
`ifdef VLIW_LOADER_CHECKSUM_EN
        CHECK: begin
          if (w_accept) begin
            if (host.host_data == r_sum) begin
              w_next     = auto_start ? RUN : IDLE;
              w_set_done = 1'b1;
            end else begin
              w_next    = ERROR;
              w_set_err = 1'b1;
            end
          end
        end
`endif
        RUN:   ;
        ERROR: ;
        default: w_next = IDLE;
      endcase
    end
  end

  // Address, word count, status flags and checksum; load_request restarts all.
  always_ff @(posedge clock_200 or negedge reset_n) begin
    if (!reset_n) begin
      r_addr  <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_last  <= 1'b0;
`ifdef VLIW_LOADER_CHECKSUM_EN
      r_sum   <= '0;
`endif
    end else if (load_request) begin
      r_addr  <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_last  <= 1'b0;
`ifdef VLIW_LOADER_CHECKSUM_EN
      r_sum   <= '0;
`endif
    end else begin
      if (r_state == WRITE) begin
        r_addr  <= r_addr + ADDR_W'(1);
        r_count <= r_count + (ADDR_W+1)'(1);
      end
      if (w_word_ready) r_last <= host.host_last;
      if (w_set_done)   r_done <= 1'b1;
      if (w_set_err)    r_err  <= 1'b1;
`ifdef VLIW_LOADER_CHECKSUM_EN
      if (w_asm_valid)  r_sum  <= r_sum + host.host_data;
`endif
    end
  end

  // Outputs decode from registered state, so none can glitch out of reset.
  assign host.host_ready = w_host_ready;
  assign write_enable    = (r_state == WRITE);
  assign write_address   = r_addr;
  assign write_data      = w_word;
  assign vliw_start      = (r_state == RUN);
  assign load_done       = r_done;
  assign load_error      = r_err;
  assign word_count      = r_count;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_vliw_program_loader.sv
// Self-checking bench for vliw_program_loader. Works in both builds; with
// VLIW_LOADER_CHECKSUM_EN defined a checksum beat follows the last word.
module tb_vliw_program_loader;
  import vliw_pkg::*;

  localparam int AW = VLIW_ADDR_W;
  localparam int DW = VLIW_DATA_W;
  localparam int EW = AW + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic load_request = 1'b0;
  logic auto_start = 1'b0;
  always #5 clk = ~clk;

  logic          write_enable;
  logic [AW-1:0] write_address;
  logic [DW-1:0] write_data;
  logic          vliw_start;
  logic          load_done;
  logic          load_error;
  logic [AW:0]   word_count;
  state_t        dbg_state;

  vliw_program_loader_if hif ();

  vliw_program_loader dut (
    .clock_200     (clk),
    .reset_n       (reset_n),
    .load_request  (load_request),
    .auto_start    (auto_start),
    .host          (hif),
    .write_enable  (write_enable),
    .write_address (write_address),
    .write_data    (write_data),
    .vliw_start    (vliw_start),
    .load_done     (load_done),
    .load_error    (load_error),
    .word_count    (word_count),
    .o_dbg_state   (dbg_state)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  logic [AW-1:0] exp_addr;
  logic [15:0]   tb_sum;

  // Every write pulse is popped against the expected {address, data}.
  always @(negedge clk) begin
    if (reset_n) begin
      if (write_enable) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: addr=%0d data=%h, required no write", write_address, write_data);
        end else begin
          mon_e = exp_q.pop_front();
          if ({write_address, write_data} !== mon_e) begin
            n_fail++;
            $display("FAIL write_data: got addr=%0d data=%h, required addr=%0d data=%h",
                     write_address, write_data, mon_e[EW-1:DW], mon_e[DW-1:0]);
          end
        end
        if (vliw_start) begin
          n_cmp++;
          n_fail++;
          $display("FAIL start_during_write: vliw_start=1 while write_enable=1, required 0");
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  function automatic logic [DW-1:0] rand_word();
    return DW'({$urandom(), $urandom(), $urandom()});
  endfunction

  // Called at posedge+1; returns at posedge+1 after the beat transferred.
  task automatic drive_beat(input logic [15:0] d, input logic l, input int gap);
    int n;
    repeat (gap) begin @(posedge clk); #1; end
    hif.host_data  = d;
    hif.host_valid = 1'b1;
    hif.host_last  = l;
    n = 0;
    @(negedge clk);
    while (hif.host_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (hif.host_ready !== 1'b1) begin
      n_cmp++;
      n_fail++;
      $display("FAIL beat_timeout: host_ready=%b after %0d cycles, required 1", hif.host_ready, n);
    end
    @(posedge clk); #1;
    hif.host_valid = 1'b0;
    hif.host_last  = 1'b0;
    hif.host_data  = '0;
  endtask

  task automatic send_word(input logic [DW-1:0] w, input logic last, input int gap_max);
    logic [15:0] b4;
    b4 = {8'($urandom_range(0, 255)), w[71:64]};
    exp_q.push_back({exp_addr, w});
    exp_addr++;
    for (int i = 0; i < 4; i++) begin
      drive_beat(w[i*16 +: 16], 1'b0, $urandom_range(0, gap_max));
      tb_sum += w[i*16 +: 16];
    end
    drive_beat(b4, last, $urandom_range(0, gap_max));
    tb_sum += b4;
  endtask

  task automatic start_load(input logic auto);
    load_request = 1'b1;
    auto_start   = auto;
    @(posedge clk); #1;
    load_request = 1'b0;
    exp_addr = '0;
    tb_sum   = '0;
  endtask

  // Completes a load after the last word has been driven.
  task automatic finish_load();
`ifdef VLIW_LOADER_CHECKSUM_EN
    drive_beat(tb_sum, 1'b0, 0);
`else
    @(negedge clk);
    n_cmp++;
    if (vliw_start !== 1'b0) begin
      n_fail++;
      $display("FAIL start_early: vliw_start=%b during last write, required 0", vliw_start);
    end
    @(posedge clk); #1;
`endif
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({write_enable, write_address, write_data, vliw_start, load_done, load_error,
         word_count, hif.host_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: we=%b addr=%0d data=%h start=%b done=%b err=%b cnt=%0d rdy=%b, required all 0",
               write_enable, write_address, write_data, vliw_start, load_done, load_error,
               word_count, hif.host_ready);
    end
    n_cmp++;
    if (dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %0d, required IDLE", dbg_state);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++;
    if (dbg_state !== IDLE || hif.host_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: state=%0d rdy=%b, required IDLE and 0", dbg_state, hif.host_ready);
    end
  endtask

  task automatic test_ten_words();
    start_load(1'b1);
    for (int i = 0; i < 10; i++) send_word(rand_word(), i == 9, 0);
    finish_load();
    n_cmp++;
    if (load_done !== 1'b1 || load_error !== 1'b0) begin
      n_fail++;
      $display("FAIL ten_status: done=%b err=%b, required 1/0", load_done, load_error);
    end
    n_cmp++;
    if (word_count !== (AW+1)'(10)) begin
      n_fail++;
      $display("FAIL ten_count: got %0d, required 10", word_count);
    end
    n_cmp++;
    if (vliw_start !== 1'b1) begin
      n_fail++;
      $display("FAIL ten_start: got %b, required 1", vliw_start);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL ten_writes: %0d writes missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_gaps();
    logic [DW-1:0] words [3];
    for (int i = 0; i < 3; i++) words[i] = rand_word();
    for (int pass = 0; pass < 2; pass++) begin
      start_load(1'b0);
      for (int i = 0; i < 3; i++) send_word(words[i], i == 2, (pass == 1) ? 4 : 0);
      finish_load();
      n_cmp++;
      if (load_done !== 1'b1 || word_count !== (AW+1)'(3)) begin
        n_fail++;
        $display("FAIL gaps_status: pass=%0d done=%b cnt=%0d, required 1/3", pass, load_done, word_count);
      end
      n_cmp++;
      if (vliw_start !== 1'b0 || dbg_state !== IDLE) begin
        n_fail++;
        $display("FAIL gaps_idle: pass=%0d start=%b state=%0d, required 0/IDLE", pass, vliw_start, dbg_state);
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL gaps_writes: pass=%0d %0d writes missing, required 0", pass, exp_q.size());
      end
    end
  endtask

  task automatic test_framing();
    start_load(1'b1);
    drive_beat(16'h1111, 1'b0, 0);
    drive_beat(16'h2222, 1'b0, 0);
    drive_beat(16'h3333, 1'b1, 0);
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++;
    if (load_error !== 1'b1 || load_done !== 1'b0 || vliw_start !== 1'b0) begin
      n_fail++;
      $display("FAIL framing_status: err=%b done=%b start=%b, required 1/0/0", load_error, load_done, vliw_start);
    end
    n_cmp++;
    if (dbg_state !== ERROR || hif.host_ready !== 1'b0 || word_count !== '0) begin
      n_fail++;
      $display("FAIL framing_state: state=%0d rdy=%b cnt=%0d, required ERROR/0/0", dbg_state, hif.host_ready, word_count);
    end
  endtask

  task automatic test_overflow();
    start_load(1'b1);
    for (int i = 0; i < 512; i++) send_word(rand_word(), 1'b0, 0);
    drive_beat(16'hABCD, 1'b0, 0);
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++;
    if (load_error !== 1'b1 || dbg_state !== ERROR || vliw_start !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_status: err=%b state=%0d start=%b, required 1/ERROR/0", load_error, dbg_state, vliw_start);
    end
    n_cmp++;
    if (word_count !== (AW+1)'(512)) begin
      n_fail++;
      $display("FAIL overflow_count: got %0d, required 512", word_count);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL overflow_writes: %0d writes missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_run_restart();
    start_load(1'b1);
    send_word(rand_word(), 1'b0, 0);
    send_word(rand_word(), 1'b1, 0);
    finish_load();
    n_cmp++;
    if (vliw_start !== 1'b1) begin
      n_fail++;
      $display("FAIL run_start: got %b, required 1", vliw_start);
    end
    start_load(1'b1);
    n_cmp++;
    if (vliw_start !== 1'b0 || dbg_state !== COLLECT || load_done !== 1'b0 || word_count !== '0) begin
      n_fail++;
      $display("FAIL run_restart: start=%b state=%0d done=%b cnt=%0d, required 0/COLLECT/0/0",
               vliw_start, dbg_state, load_done, word_count);
    end
    send_word(rand_word(), 1'b1, 0);
    finish_load();
    n_cmp++;
    if (vliw_start !== 1'b1 || word_count !== (AW+1)'(1) || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL run_reload: start=%b cnt=%0d missing=%0d, required 1/1/0", vliw_start, word_count, exp_q.size());
    end
  endtask

  task automatic test_coincident();
    start_load(1'b0);
    drive_beat(16'hDEAD, 1'b0, 0);
    hif.host_data  = 16'hBEEF;
    hif.host_valid = 1'b1;
    load_request   = 1'b1;
    @(posedge clk); #1;
    load_request   = 1'b0;
    hif.host_valid = 1'b0;
    exp_addr = '0;
    tb_sum   = '0;
    send_word(rand_word(), 1'b1, 0);
    finish_load();
    n_cmp++;
    if (load_done !== 1'b1 || word_count !== (AW+1)'(1) || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL coincident: done=%b cnt=%0d missing=%0d, required 1/1/0", load_done, word_count, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_load();
    start_load(1'b1);
    for (int i = 0; i < 4; i++) drive_beat(16'($urandom()), 1'b0, 0);
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({write_enable, vliw_start, load_done, load_error, word_count, hif.host_ready} !== '0 ||
        dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL midload_reset: we=%b start=%b cnt=%0d state=%0d, required 0/0/0/IDLE",
               write_enable, vliw_start, word_count, dbg_state);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    n_cmp++;
    if (dbg_state !== IDLE || word_count !== '0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL midload_release: state=%0d cnt=%0d, required IDLE/0", dbg_state, word_count);
    end
  endtask

`ifdef VLIW_LOADER_CHECKSUM_EN
  task automatic test_checksum_bad();
    start_load(1'b1);
    send_word(rand_word(), 1'b0, 0);
    send_word(rand_word(), 1'b1, 0);
    drive_beat(tb_sum + 16'd1, 1'b0, 0);
    n_cmp++;
    if (load_error !== 1'b1 || load_done !== 1'b0 || vliw_start !== 1'b0 || dbg_state !== ERROR) begin
      n_fail++;
      $display("FAIL checksum_bad: err=%b done=%b start=%b state=%0d, required 1/0/0/ERROR",
               load_error, load_done, vliw_start, dbg_state);
    end
  endtask
`endif

  initial begin
    hif.host_data  = '0;
    hif.host_valid = 1'b0;
    hif.host_last  = 1'b0;
    exp_addr = '0;
    tb_sum   = '0;
    test_reset();
    test_ten_words();
    test_gaps();
    test_framing();
    test_overflow();
    test_run_restart();
    test_coincident();
    test_reset_mid_load();
`ifdef VLIW_LOADER_CHECKSUM_EN
    test_checksum_bad();
`endif
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
